// File: rtl/packet_arbiter_mux.sv
// ---------------------------------------------------------------------------
// packet_arbiter_mux
//
// Purpose:
//   Packet-level N:1 valid/ready stream multiplexer. An idle block grants the
//   lowest-indexed input that presents valid (index 0 has the highest
//   priority). The grant then stays locked to that input until the beat
//   carrying i_in_last is accepted, so frames never interleave. The output
//   is one registered pipeline stage. Between frames there is one idle
//   (arbitration) cycle.
//
// Optional feature (compile-time macro PACKET_ARB_TIMEOUT_EN):
//   A stall watchdog releases the lock when the locked input has had valid
//   low for TIMEOUT_CYCLES counted cycles. When it fires, o_timeout_pulse is
//   high for that one cycle. Without the macro the counter is not built,
//   o_timeout_pulse is tied low, and the lock is held until in_last.
//
// Parameters:
//   NUM_INPUTS      number of input streams (>= 2)
//   DATA_WIDTH      beat width in bits
//   TIMEOUT_CYCLES  watchdog limit (used only with PACKET_ARB_TIMEOUT_EN)
//   SEL_WIDTH       index width, derived from NUM_INPUTS
//
// Ports:
//   i_clk           clock, all logic on the rising edge
//   i_reset         asynchronous active-high reset
//   i_in_data       input beats, input i at [i*DATA_WIDTH +: DATA_WIDTH]
//   i_in_valid      per-input beat valid
//   i_in_last       per-input end-of-frame flag
//   o_in_ready      per-input accept (only the locked input can be ready)
//   o_out_data      registered output beat
//   o_out_valid     output beat valid
//   o_out_last      output end-of-frame
//   i_out_ready     downstream accept
//   o_active_index  currently locked input
//   o_locked        high while a frame is being forwarded
//   o_timeout_pulse one-cycle pulse when the watchdog releases the lock
// ---------------------------------------------------------------------------
module packet_arbiter_mux #(
    parameter int NUM_INPUTS     = 4,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int SEL_WIDTH      = $clog2(NUM_INPUTS)
) (
    input  logic                             i_clk,
    input  logic                             i_reset,
    input  logic [NUM_INPUTS*DATA_WIDTH-1:0] i_in_data,
    input  logic [NUM_INPUTS-1:0]            i_in_valid,
    input  logic [NUM_INPUTS-1:0]            i_in_last,
    output logic [NUM_INPUTS-1:0]            o_in_ready,
    output logic [DATA_WIDTH-1:0]            o_out_data,
    output logic                             o_out_valid,
    output logic                             o_out_last,
    input  logic                             i_out_ready,
    output logic [SEL_WIDTH-1:0]             o_active_index,
    output logic                             o_locked,
    output logic                             o_timeout_pulse
);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [SEL_WIDTH-1:0]   r_active_index;
    logic [SEL_WIDTH-1:0]   w_index_next;
    logic [SEL_WIDTH-1:0]   w_req_idx;
    logic [DATA_WIDTH-1:0]  r_out_data;
    logic                   r_out_valid;
    logic                   r_out_last;

    logic                   w_locked;
    logic                   w_slot_free;
    logic                   w_sel_valid;
    logic                   w_sel_last;
    logic [DATA_WIDTH-1:0]  w_sel_data;
    logic                   w_accept;
    logic                   w_timeout;

    logic [DATA_WIDTH-1:0]  w_in_data [NUM_INPUTS];

    // Unpack the flat data bus and build the per-input ready vector.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_INPUTS; gi++) begin : g_inputs
            assign w_in_data[gi]  = i_in_data[gi*DATA_WIDTH +: DATA_WIDTH];
            assign o_in_ready[gi] = w_locked && w_slot_free &&
                                    (r_active_index == SEL_WIDTH'(gi));
        end
    endgenerate

    assign w_locked    = (r_state == ST_LOCKED);
    // The output register can take a beat when empty or draining this cycle.
    // Deliberately independent of the locked input's own valid.
    assign w_slot_free = !r_out_valid || i_out_ready;
    assign w_sel_valid = i_in_valid[r_active_index];
    assign w_sel_last  = i_in_last[r_active_index];
    assign w_sel_data  = w_in_data[r_active_index];
    assign w_accept    = w_locked && w_sel_valid && w_slot_free;

    // Lowest set valid bit wins; scanning downward leaves the lowest index.
    always_comb begin
        w_req_idx = '0;
        for (int i = NUM_INPUTS - 1; i >= 0; i--) begin
            if (i_in_valid[i]) begin
                w_req_idx = SEL_WIDTH'(i);
            end
        end
    end

`ifdef PACKET_ARB_TIMEOUT_EN
    localparam int CNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_WIDTH-1:0] r_stall_cnt;

    // Counts cycles the locked input holds valid low; a cycle where the input
    // is valid but backpressured is not a stall. An accept in the same cycle
    // as the limit wins, because that input is evidently not stuck.
    assign w_timeout = w_locked && !w_accept &&
                       (r_stall_cnt == CNT_WIDTH'(TIMEOUT_CYCLES));

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_stall_cnt <= '0;
        end else if (!w_locked || w_accept) begin
            // Held at zero while idle, so every entry to LOCKED starts clean.
            r_stall_cnt <= '0;
        end else if (!w_sel_valid &&
                     (r_stall_cnt != CNT_WIDTH'(TIMEOUT_CYCLES))) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    // FSM: state and grant index registers.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state        <= ST_IDLE;
            r_active_index <= '0;
        end else begin
            r_state        <= w_state_next;
            r_active_index <= w_index_next;
        end
    end

    // FSM: next-state logic. Arbitration happens only in IDLE, so requests
    // from other inputs during a frame are simply not looked at.
    always_comb begin
        w_state_next = r_state;
        w_index_next = r_active_index;
        case (r_state)
            ST_IDLE: begin
                if (|i_in_valid) begin
                    w_state_next = ST_LOCKED;
                    w_index_next = w_req_idx;
                end
            end
            ST_LOCKED: begin
                if ((w_accept && w_sel_last) || w_timeout) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Output stage. A newly accepted beat overwrites a beat leaving this same
    // cycle, which gives full throughput; otherwise the beat holds until
    // taken. A watchdog release leaves any registered beat to drain normally.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_data  <= '0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_last  <= w_sel_last;
            r_out_data  <= w_sel_data;
        end else if (i_out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign o_out_data      = r_out_data;
    assign o_out_valid     = r_out_valid;
    assign o_out_last      = r_out_last;
    assign o_active_index  = r_active_index;
    assign o_locked        = w_locked;
    assign o_timeout_pulse = w_timeout;

endmodule

// File: tb/tb_packet_arbiter_mux.sv
// ---------------------------------------------------------------------------
// tb_packet_arbiter_mux
//
// Bench for packet_arbiter_mux (NUM_INPUTS=4, DATA_WIDTH=32,
// TIMEOUT_CYCLES=4). It contains:
//   - a reset-value check;
//   - a table of arbitration vectors (valid pattern -> granted index);
//   - hand-written sequences: priority, no interleave, backpressure,
//     reset mid-frame, and watchdog (on or off, depending on
//     PACKET_ARB_TIMEOUT_EN);
//   - randomized frames and out_ready, checked against a frame-order model.
//
// Sources keep valid high at every frame start. Under fixed priority, the
// expected output is then each input's frames, in input-index order.
// Mid-frame valid gaps and random out_ready change the timing only.
// ---------------------------------------------------------------------------
module tb_packet_arbiter_mux;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int TO = 4;
    localparam int SW = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [N*DW-1:0]   in_data;
    logic [N-1:0]      in_valid;
    logic [N-1:0]      in_last;
    logic [N-1:0]      in_ready;
    logic [DW-1:0]     out_data;
    logic              out_valid;
    logic              out_last;
    logic              out_ready;
    logic [SW-1:0]     active_index;
    logic              locked;
    logic              timeout_pulse;

    always #5 clk = ~clk;

    packet_arbiter_mux #(
        .NUM_INPUTS     (N),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .i_clk           (clk),
        .i_reset         (rst),
        .i_in_data       (in_data),
        .i_in_valid      (in_valid),
        .i_in_last       (in_last),
        .o_in_ready      (in_ready),
        .o_out_data      (out_data),
        .o_out_valid     (out_valid),
        .o_out_last      (out_last),
        .i_out_ready     (out_ready),
        .o_active_index  (active_index),
        .o_locked        (locked),
        .o_timeout_pulse (timeout_pulse)
    );

    int n_vec = 0;
    int n_err = 0;

    // Source and scoreboard state. A beat is stored as {last, data}.
    logic [DW:0] src_q [N][$];
    int          src_start [N];
    int          src_stall [N];   // stop driving after this many accepts, -1 = never
    int          src_acc   [N];
    bit          src_mid   [N];
    int          src_gap   [N];
    logic [DW:0] exp_q [$];
    bit          gaps_en;
    bit          ready_rand;
    int          stall_lo;
    int          stall_hi;
    int          cyc;

    typedef struct {
        logic [N-1:0]  valid;
        logic          exp_locked;
        logic [SW-1:0] exp_idx;
    } arb_vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s (cycle %0d): got 0x%0h, required 0x%0h", name, cyc, act, exp);
        end
    endtask

    task automatic clear_srcs();
        for (int s = 0; s < N; s++) begin
            src_q[s].delete();
            src_start[s] = 0;
            src_stall[s] = -1;
            src_acc[s]   = 0;
            src_mid[s]   = 1'b0;
            src_gap[s]   = 0;
        end
        exp_q.delete();
        gaps_en    = 1'b0;
        ready_rand = 1'b0;
        stall_lo   = -1;
        stall_hi   = -1;
        cyc        = 0;
    endtask

    task automatic add_frame(input int s, input int len, input logic [DW-1:0] base, input bit to_exp);
        for (int b = 0; b < len; b++) begin
            logic [DW:0] beat;
            beat = {(b == len - 1), base + DW'(b)};
            src_q[s].push_back(beat);
            if (to_exp) exp_q.push_back(beat);
        end
    endtask

    task automatic drive_inputs();
        for (int s = 0; s < N; s++) begin
            logic v;
            v = 1'b0;
            if (src_q[s].size() > 0 && cyc >= src_start[s] &&
                !(src_stall[s] >= 0 && src_acc[s] >= src_stall[s])) begin
                v = 1'b1;
                if (gaps_en && src_mid[s] && src_gap[s] < 2 && $urandom_range(3) == 0) v = 1'b0;
            end
            src_gap[s] = (!v && src_mid[s]) ? src_gap[s] + 1 : 0;
            in_valid[s] = v;
            in_last[s]  = (src_q[s].size() > 0) ? src_q[s][0][DW] : 1'b0;
            in_data[s*DW +: DW] = (src_q[s].size() > 0) ? src_q[s][0][DW-1:0] : '0;
        end
        if (ready_rand) out_ready = ($urandom_range(3) != 0);
        else            out_ready = !(cyc >= stall_lo && cyc <= stall_hi);
    endtask

    // Score this cycle's output handshake, log the accepted inputs, then move
    // on to the next cycle. Returns at negedge+1 with the new inputs driven.
    task automatic advance();
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_beat (cycle %0d): got data 0x%0h, required no beat", cyc, out_data);
            end else begin
                logic [DW:0] e;
                e = exp_q.pop_front();
                chk("out_data", 64'(out_data), 64'(e[DW-1:0]));
                chk("out_last", 64'(out_last), 64'(e[DW]));
                $display("beat cycle %0d: data=0x%08h last=%0b", cyc, out_data, out_last);
            end
        end
        for (int s = 0; s < N; s++) begin
            if (in_valid[s] && in_ready[s]) begin
                logic [DW:0] b;
                b = src_q[s].pop_front();
                src_acc[s]++;
                src_mid[s] = !b[DW];
            end
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
        drive_inputs();
        #1;
    endtask

    task automatic begin_seq();
        @(negedge clk);
        cyc = 0;
        drive_inputs();
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b1;
        in_valid = '0;
        @(negedge clk);
        rst      = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_out_valid"}, 64'(out_valid), 64'(0));
        chk({tag, "_out_last"},  64'(out_last),  64'(0));
        chk({tag, "_out_data"},  64'(out_data),  64'(0));
        chk({tag, "_in_ready"},  64'(in_ready),  64'(0));
        chk({tag, "_index"},     64'(active_index), 64'(0));
        chk({tag, "_locked"},    64'(locked),    64'(0));
        chk({tag, "_pulse"},     64'(timeout_pulse), 64'(0));
    endtask

    initial begin
        arb_vec_t    vecs [9];
        logic [N-1:0] er;
        int          guard;

        vecs[0] = '{4'b0000, 1'b0, 2'd0};
        vecs[1] = '{4'b0001, 1'b1, 2'd0};
        vecs[2] = '{4'b0010, 1'b1, 2'd1};
        vecs[3] = '{4'b0100, 1'b1, 2'd2};
        vecs[4] = '{4'b1000, 1'b1, 2'd3};
        vecs[5] = '{4'b1010, 1'b1, 2'd1};
        vecs[6] = '{4'b1100, 1'b1, 2'd2};
        vecs[7] = '{4'b1111, 1'b1, 2'd0};
        vecs[8] = '{4'b0110, 1'b1, 2'd1};

        rst       = 1'b1;
        in_data   = '0;
        in_valid  = '0;
        in_last   = '0;
        out_ready = 1'b0;
        clear_srcs();

        // Reset values.
        #2;
        chk_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0;

        // Arbitration table: one idle cycle with a valid pattern, then check
        // the grant, and clear the state again with an asynchronous reset.
        for (int i = 0; i < 9; i++) begin
            in_valid  = vecs[i].valid;
            in_last   = '1;
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            er = vecs[i].exp_locked ? (N'(1) << vecs[i].exp_idx) : '0;
            chk("arb_locked", 64'(locked), 64'(vecs[i].exp_locked));
            chk("arb_index",  64'(active_index), 64'(vecs[i].exp_idx));
            chk("arb_ready",  64'(in_ready), 64'(er));
            chk("arb_out_valid", 64'(out_valid), 64'(0));
            @(negedge clk);
            rst      = 1'b1;
            in_valid = '0;
            #1;
            rst      = 1'b0;
        end

        // Priority: inputs 1 and 3 request together, 3 beats each.
        do_reset();
        clear_srcs();
        add_frame(1, 3, 32'h100, 1'b1);
        add_frame(3, 3, 32'h300, 1'b1);
        begin_seq();
        for (int c = 0; c < 10; c++) begin
            chk("prio_out_valid", 64'(out_valid), 64'(c inside {2, 3, 4, 6, 7, 8}));
            chk("prio_out_last",  64'(out_last && out_valid), 64'(c == 4 || c == 8));
            advance();
        end
        chk("prio_drain", 64'(exp_q.size()), 64'(0));

        // No interleave: input 0 shows up while input 2 is mid-frame.
        do_reset();
        clear_srcs();
        add_frame(2, 4, 32'h200, 1'b1);
        add_frame(0, 2, 32'h000, 1'b1);
        src_start[0] = 3;
        begin_seq();
        for (int c = 0; c < 11; c++) begin
            chk("nointlv_ready0", 64'(in_ready[0]), 64'(c == 6 || c == 7));
            if (c >= 1 && c <= 4) chk("nointlv_index", 64'(active_index), 64'(2));
            advance();
        end
        chk("nointlv_drain", 64'(exp_q.size()), 64'(0));

        // Backpressure: out_ready low for cycles 4..8 of an 8-beat frame.
        do_reset();
        clear_srcs();
        add_frame(0, 8, 32'hA0, 1'b1);
        stall_lo = 4;
        stall_hi = 8;
        begin_seq();
        for (int c = 0; c < 17; c++) begin
            if (c >= 4 && c <= 8) begin
                chk("bp_ready",     64'(in_ready[0]), 64'(0));
                chk("bp_out_valid", 64'(out_valid), 64'(1));
                chk("bp_out_data",  64'(out_data), 64'(32'hA2));
            end
            advance();
        end
        chk("bp_drain", 64'(exp_q.size()), 64'(0));

        // Reset mid-frame: asserted between edges while beat 2 of 4 is held.
        do_reset();
        clear_srcs();
        add_frame(0, 4, 32'hB0, 1'b0);
        exp_q.push_back({1'b0, 32'hB0});
        begin_seq();
        for (int c = 0; c < 3; c++) advance();
        rst      = 1'b1;
        in_valid = '0;
        #1;
        chk_reset_outputs("midrst");
        chk("midrst_delivered", 64'(exp_q.size()), 64'(0));
        clear_srcs();
        #1;
        rst = 1'b0;
        add_frame(0, 3, 32'hC0, 1'b1);
        begin_seq();
        for (int c = 0; c < 8; c++) advance();
        chk("midrst_drain", 64'(exp_q.size()), 64'(0));

        // Watchdog: input 1 stalls after its first beat; input 3 waits.
        do_reset();
        clear_srcs();
        add_frame(1, 3, 32'h110, 1'b0);
        exp_q.push_back({1'b0, 32'h110});
        src_stall[1] = 1;
`ifdef PACKET_ARB_TIMEOUT_EN
        add_frame(3, 2, 32'h330, 1'b1);
        begin_seq();
        for (int c = 0; c < 15; c++) begin
            chk("to_pulse", 64'(timeout_pulse), 64'(c == 6));
            if (c == 7) chk("to_unlocked", 64'(locked), 64'(0));
            if (c == 8) begin
                chk("to_relocked", 64'(locked), 64'(1));
                chk("to_grant3",   64'(active_index), 64'(3));
            end
            advance();
        end
`else
        add_frame(3, 2, 32'h330, 1'b0);
        begin_seq();
        for (int c = 0; c < 101; c++) begin
            chk("nto_pulse", 64'(timeout_pulse), 64'(0));
            if (c >= 1) chk("nto_locked", 64'(locked && active_index == 2'd1), 64'(1));
            advance();
        end
`endif
        chk("to_drain", 64'(exp_q.size()), 64'(0));

        // Randomized frames, mid-frame valid gaps and random out_ready.
        for (int t = 0; t < 4; t++) begin
            do_reset();
            clear_srcs();
            gaps_en    = 1'b1;
            ready_rand = 1'b1;
            for (int s = 0; s < N; s++) begin
                int nf;
                nf = $urandom_range(3);
                for (int f = 0; f < nf; f++) begin
                    add_frame(s, $urandom_range(5, 1), $urandom, 1'b1);
                end
            end
            begin_seq();
            guard = 0;
            while (exp_q.size() > 0 && guard < 3000) begin
                advance();
                guard++;
            end
            chk("rand_drain", 64'(exp_q.size()), 64'(0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
